i2s_frame_arbiter: RTL

Shares the I2S transmitter's 32-slot sample frame between several stimulus requesters. Each requester writes (slot, byte) pairs through a valid/ready handshake into a shadow frame buffer under round-robin arbitration. The buffer is double-buffered: at each transmitter frame boundary the shadow is committed to the active frame that drives the transmitter's audio_data input. Sits between the stimulus generators and the I2S transmitter, all in the system clock domain.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_frame_arbiter_if.sv | 16 +
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/i2s_frame_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S frame arbiter: slot geometry, sample/frame types, FSM states.
package i2s_pkg;

  localparam int unsigned NUM_SLOTS = 32;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);

  typedef logic [DATA_W-1:0] sample_t;
  typedef sample_t frame_t [NUM_SLOTS];

  typedef enum logic {
    ACCEPT,
    SWAP
  } arb_state_t;

endpackage

// File: rtl/i2s_frame_arbiter_if.sv
// Requester-side write handshake bundle: per-requester valid/slot/data in, one-hot ready back.
interface i2s_frame_arbiter_if
  import i2s_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][SLOT_W-1:0] req_slot;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;

  modport master (output req_valid, req_slot, req_data, input req_ready);
  modport slave  (input req_valid, req_slot, req_data, output req_ready);

endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant arbiter; round-robin by default, fixed lowest-index priority when
// I2S_ARB_FIXED_PRIO_EN is defined (pointer register removed in that build).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

`ifdef I2S_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, reset_n, advance};

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win;
  logic             found;

  // Scan starts at the pointer and wraps, so the first hit is the RR winner.
  always_comb begin
    int unsigned idx;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        win                   = idx[PTR_W-1:0];
        found                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

`endif

endmodule

// File: rtl/i2s_frame_arbiter.sv
// Arbitrates requester slot writes into a shadow frame and commits it to the active
// frame at each transmitter frame boundary. I2S_ARB_FIXED_PRIO_EN selects fixed priority.
module i2s_frame_arbiter
  import i2s_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  i2s_frame_arbiter_if.slave  req,
  input  logic                frame_done,
  output frame_t              frame_data,
  output logic                swap_pulse,
  output logic                frame_full,
  output logic [7:0]          underrun_cnt
);

  arb_state_t           state_q, state_d;
  frame_t               shadow_q, active_q;
  logic [NUM_SLOTS-1:0] mask_q;
  logic [7:0]           underrun_q;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic                 xfer;
  logic [SLOT_W-1:0]    wslot;
  sample_t              wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is gated by reset_n so no grant is shown while reset is held.
  always_comb begin
    state_d       = state_q;
    swap_pulse    = 1'b0;
    accept        = 1'b0;
    req.req_ready = '0;
    case (state_q)
      ACCEPT: begin
        accept        = reset_n;
        req.req_ready = reset_n ? grant : '0;
        if (frame_done) state_d = SWAP;
      end
      SWAP: begin
        swap_pulse = 1'b1;
        state_d    = ACCEPT;
      end
    endcase
  end

  always_comb begin
    wslot = '0;
    wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req.req_ready[i]) begin
        wslot = req.req_slot[i];
        wdata = req.req_data[i];
      end
    end
    xfer = |req.req_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACCEPT;
    else          state_q <= state_d;
  end

  // Shadow is never cleared on commit: unwritten slots repeat their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
      mask_q     <= '0;
      underrun_q <= '0;
    end else if (state_q == SWAP) begin
      active_q <= shadow_q;
      mask_q   <= '0;
      if (!(&mask_q) && underrun_q != 8'hFF) underrun_q <= underrun_q + 8'd1;
    end else if (xfer && 32'(wslot) < NUM_SLOTS) begin
      shadow_q[wslot] <= wdata;
      mask_q[wslot]   <= 1'b1;
    end
  end

  assign frame_data   = active_q;
  assign frame_full   = &mask_q;
  assign underrun_cnt = underrun_q;

endmodule
